multiword_add_seq: RTL and testbench

- Sequential multi-word add/subtract engine that drives a single combinational `cla32btadder` instance.
- Accepts operands as a stream of 32-bit word pairs, least-significant word first, over a valid/ready handshake.
- Carries the adder's carry-out between beats and emits one sum word per accepted beat through a registered output stage.
- Provides arbitrary-precision (up to MAX_BEATS x 32-bit) add/sub for the datapath built around the 32-bit CLA adder.

---
 rtl/multiword_add_seq_if.sv | 27 ++
 rtl/multiword_add_seq.sv | 119 +++++++++++
 tb/tb_multiword_add_seq.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/multiword_add_seq_if.sv
// Stream bundle for the multi-word add/sub engine: an operand-pair input stream
// and a result-word output stream, each with its own valid/ready handshake.
interface multiword_add_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sub;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_last;
  logic        out_cout;
  logic        out_ovf;
  logic        out_err;

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_last, out_cout, out_ovf, out_err
  );

  modport master (
    output in_valid, in_a, in_b, in_sub, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_last, out_cout, out_ovf, out_err
  );
endinterface

// File: rtl/multiword_add_seq.sv
// Sequential multi-word add/subtract engine: streams 32-bit word pairs LSW first
// through one 32-bit carry-lookahead adder, chaining the carry between beats.
module cla32btadder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;
  logic [7:0]  gg;
  logic [7:0]  gp;

  always_comb begin
    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
    g  = a & b;
    p  = a ^ b;
    c  = '0;
    gg = '0;
    gp = '0;
    c[0] = cin;
    // Eight 4-bit lookahead groups; group generate/propagate form the next group carry.
    for (int blk = 0; blk < 8; blk++) begin
      c[blk*4+1] = g[blk*4] | (p[blk*4] & c[blk*4]);
      c[blk*4+2] = g[blk*4+1] | (p[blk*4+1] & g[blk*4])
                 | (p[blk*4+1] & p[blk*4] & c[blk*4]);
      c[blk*4+3] = g[blk*4+2] | (p[blk*4+2] & g[blk*4+1])
                 | (p[blk*4+2] & p[blk*4+1] & g[blk*4])
                 | (p[blk*4+2] & p[blk*4+1] & p[blk*4] & c[blk*4]);
      gg[blk]    = g[blk*4+3] | (p[blk*4+3] & g[blk*4+2])
                 | (p[blk*4+3] & p[blk*4+2] & g[blk*4+1])
                 | (p[blk*4+3] & p[blk*4+2] & p[blk*4+1] & g[blk*4]);
      gp[blk]    = &p[blk*4 +: 4];
      c[blk*4+4] = gg[blk] | (gp[blk] & c[blk*4]);
    end
    sum  = p ^ c[31:0];
    cout = c[32];
  end
endmodule

module multiword_add_seq #(
  parameter int MAX_BEATS = 8,
  parameter int CNT_W     = 3
) (
  input  logic                clk,
  input  logic                rst,
  multiword_add_seq_if.slave  bus,
  output logic                busy
);
  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   beat_cnt;
  logic               carry_q;
  logic               sub_q;

  logic               acc;
  logic               eff_sub;
  logic               term;
  logic               cin;
  logic [31:0]        b_eff;
  logic [31:0]        sum;
  logic               cout;

  // Ready passes out_ready straight through so a draining output slot refills in the same cycle.
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign acc          = bus.in_valid && bus.in_ready;

  // Mode and carry-in come from the live inputs on a first beat, from stored state afterwards.
  assign eff_sub = (state == IDLE) ? bus.in_sub : sub_q;
  assign b_eff   = eff_sub ? ~bus.in_b : bus.in_b;
  assign cin     = (state == IDLE) ? bus.in_sub : carry_q;
  assign term    = bus.in_last || (beat_cnt == CNT_W'(MAX_BEATS - 1));
  assign busy    = (state == ACTIVE);

  cla32btadder u_adder (
    .a    (bus.in_a),
    .b    (b_eff),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      carry_q       <= 1'b0;
      sub_q         <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_last  <= 1'b0;
      bus.out_cout  <= 1'b0;
      bus.out_ovf   <= 1'b0;
      bus.out_err   <= 1'b0;
    end else if (acc) begin
      bus.out_valid <= 1'b1;
      bus.out_sum   <= sum;
      bus.out_last  <= term;
      bus.out_cout  <= term ? cout : 1'b0;
      bus.out_ovf   <= term ? ((bus.in_a[31] == b_eff[31]) && (sum[31] != bus.in_a[31])) : 1'b0;
      bus.out_err   <= term && !bus.in_last;
      carry_q       <= cout;
      if (state == IDLE) begin
        sub_q    <= bus.in_sub;
        state    <= term ? IDLE : ACTIVE;
        beat_cnt <= term ? '0 : CNT_W'(1);
      end else begin
        state    <= term ? IDLE : ACTIVE;
        beat_cnt <= term ? '0 : beat_cnt + CNT_W'(1);
      end
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq: directed cases plus random multi-word
// operations, compared against a wide-integer arithmetic model of each operation.
module tb_multiword_add_seq;
  localparam int MAX_BEATS = 8;

  typedef struct {
    logic [31:0] sum;
    logic        last;
    logic        cout;
    logic        ovf;
    logic        err;
    logic        busy;
  } exp_t;

  logic clk;
  logic rst;
  logic busy;
  int   errors = 0;
  int   checks = 0;

  // Model state: operands of the current operation accumulated as wide integers.
  logic [255:0] m_a;
  logic [255:0] m_b;
  logic         m_sub;
  int           m_k;

  multiword_add_seq_if bus ();

  multiword_add_seq #(.MAX_BEATS(MAX_BEATS), .CNT_W(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_k   = 0;
    m_a   = '0;
    m_b   = '0;
    m_sub = 1'b0;
  endtask

  // Result word k of an operation is word k of (A + B' + sub) over the words seen so far.
  task automatic model_beat(input logic [31:0] a, input logic [31:0] b, input logic sub,
                            input logic last, output exp_t e);
    logic [31:0]  beff;
    logic [256:0] full;
    logic         t;
    if (m_k == 0) begin
      m_sub = sub;
      m_a   = '0;
      m_b   = '0;
    end
    beff = m_sub ? ~b : b;
    m_a[m_k*32 +: 32] = a;
    m_b[m_k*32 +: 32] = beff;
    full   = {1'b0, m_a} + {1'b0, m_b} + 257'(m_sub);
    t      = last || (m_k == MAX_BEATS - 1);
    e.sum  = full[m_k*32 +: 32];
    e.last = t;
    e.cout = t ? full[(m_k+1)*32] : 1'b0;
    e.ovf  = t ? ((a[31] == beff[31]) && (e.sum[31] != a[31])) : 1'b0;
    e.err  = t && !last;
    e.busy = !t;
    m_k    = t ? 0 : m_k + 1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic last);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sub   = sub;
    bus.in_last  = last;
  endtask

  task automatic expect_out(input string tag, input exp_t e);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".sum"},   bus.out_sum,         e.sum);
    check({tag, ".last"},  32'(bus.out_last),  32'(e.last));
    check({tag, ".cout"},  32'(bus.out_cout),  32'(e.cout));
    check({tag, ".ovf"},   32'(bus.out_ovf),   32'(e.ovf));
    check({tag, ".err"},   32'(bus.out_err),   32'(e.err));
    check({tag, ".busy"},  32'(busy),          32'(e.busy));
  endtask

  // One beat with out_ready held high: wait for ready, accept, then check the result word.
  task automatic send(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic sub, input logic last);
    exp_t e;
    int   n;
    drive(a, b, sub, last);
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n == 20) check({tag, ".ready_wait"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    model_beat(a, b, sub, last, e);
    expect_out(tag, e);
  endtask

  initial begin
    exp_t ex;
    exp_t ey;
    logic [31:0] ra;
    logic [31:0] rb;
    int len;
    logic rsub;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sub    = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", 32'(bus.out_valid), 32'd0);
    check("rst.sum",   bus.out_sum,        32'd0);
    check("rst.flags", {28'd0, bus.out_last, bus.out_cout, bus.out_ovf, bus.out_err}, 32'd0);
    check("rst.busy",  32'(busy),          32'd0);
    check("rst.ready", 32'(bus.in_ready),  32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single-beat add with carry out.
    send("add1", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
    // Two-beat 64-bit add, consecutive beats.
    send("add64.w0", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    send("add64.w1", 32'h0,         32'h0, 1'b0, 1'b1);
    // Single-beat subtracts.
    send("sub.5m7",  32'd5,         32'd7, 1'b1, 1'b1);
    send("sub.ovf",  32'h8000_0000, 32'h1, 1'b1, 1'b1);
    // in_sub dropped on the second beat must be ignored.
    send("sub2.w0",  32'h0,         32'h1, 1'b1, 1'b0);
    send("sub2.w1",  32'h5,         32'h2, 1'b0, 1'b1);
    check("sub2.sum_direct", bus.out_sum, 32'h2);

    // Backpressure: one word parked in the output, a second waits for 3 cycles.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send("bp.x", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
    ex = '{sum: 32'h2345_6789, last: 1'b1, cout: 1'b0, ovf: 1'b0, err: 1'b0, busy: 1'b0};
    drive(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp.in_ready", 32'(bus.in_ready), 32'd0);
      expect_out("bp.hold", ex);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp.release_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    model_beat(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1, ey);
    expect_out("bp.y", ey);
    check("bp.y_direct", bus.out_sum, 32'h30);

    // Overrun: eight non-last beats force termination with out_err.
    for (int i = 0; i < MAX_BEATS; i++) send("ovr", 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
    check("ovr.err_direct", 32'(bus.out_err), 32'd1);
    // Next beat is a first beat again: 5 - 3 with cin taken from in_sub.
    send("ovr.next", 32'd5, 32'd3, 1'b1, 1'b1);
    check("ovr.next_direct", bus.out_sum, 32'd2);

    // Reset mid-operation discards partial state.
    send("rmid.w0", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("rmid.valid", 32'(bus.out_valid), 32'd0);
    check("rmid.sum",   bus.out_sum,        32'd0);
    check("rmid.flags", {28'd0, bus.out_last, bus.out_cout, bus.out_ovf, bus.out_err}, 32'd0);
    check("rmid.busy",  32'(busy),          32'd0);
    send("rmid.add", 32'd2, 32'd3, 1'b0, 1'b1);
    check("rmid.add_direct", bus.out_sum, 32'd5);

    // Random multi-word operations; carry-heavy operands are mixed in often.
    for (int op = 0; op < 24; op++) begin
      len  = $urandom_range(1, 9);
      rsub = 1'($urandom_range(0, 1));
      for (int k = 0; k < len; k++) begin
        ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        rb = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        send("rnd", ra, rb, (k == 0) ? rsub : 1'($urandom_range(0, 1)), k == len - 1);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
          check("rnd.idle_valid", 32'(bus.out_valid), 32'd0);
        end
      end
      // A 9-word request is cut at 8 words; its ninth word begins a new single-word op.
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
